// File: rtl/adc_capture_fifo.sv
// ADC capture channel: averages 2^AVG_LOG2 strobed samples per result and
// queues results in a show-ahead FIFO with a sticky overflow flag.
module adc_capture_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AVG_LOG2   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       sample_strobe,
    input  logic [DATA_WIDTH-1:0]      ADC_code,
    input  logic                       clear,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNTW  = PW + 1;
    localparam int AW    = DATA_WIDTH + AVG_LOG2;
    localparam int CW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int GROUP = 1 << AVG_LOG2;

    logic [AW-1:0]         acc_q, acc_d, sum;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, nxt_rd;
    logic [CNTW-1:0]       count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, wdata;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic accept, last, push, pop, push_ok, empty, full;

    assign accept  = en && sample_strobe && !clear;
    assign last    = (cnt_q == CW'(GROUP - 1));
    assign sum     = acc_q + AW'(ADC_code);
    assign wdata   = DATA_WIDTH'(sum >> AVG_LOG2);
    assign push    = accept && last;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNTW'(DEPTH));
    assign pop     = rd_en && !empty && !clear;
    assign push_ok = push && (!full || pop);
    assign nxt_rd  = rd_ptr_q + PW'(1);

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;
        if (clear) begin
            acc_d    = '0;
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            // Leaving capture discards any partial group.
            if (!en) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (sample_strobe) begin
                acc_d = last ? '0 : sum;
                cnt_d = last ? '0 : cnt_q + CW'(1);
            end
            if (push && full && !pop)
                ovf_d = 1'b1;
            if (push_ok)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_d = nxt_rd;
            count_d = count_q + CNTW'(push_ok) - CNTW'(pop);
            // Head register follows the entry that becomes the new head.
            if (pop && count_q > CNTW'(1))
                dout_d = mem[nxt_rd];
            else if (push_ok && (empty || pop))
                dout_d = wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear)
            mem[wr_ptr_q] <= wdata;
    end

    assign data_out   = dout_q;
    assign data_valid = !empty;
    assign count      = count_q;
    assign overflow   = ovf_q;
endmodule
